// File: rtl/core_mac_acc.sv
// Pipelined multi-lane dot-product engine: S0 operand regs, S1 products, pipelined adder tree,
// then a wide per-vector accumulator. Define CORE_MAC_SAT_EN for saturating accumulation.
module core_mac_acc #(
    parameter int unsigned MAC_NUM   = 4,
    parameter int unsigned IDATA_BIT = 8,
    parameter int unsigned SUM_BIT   = 2 * IDATA_BIT + $clog2(MAC_NUM),
    parameter int unsigned ACC_BIT   = SUM_BIT + 8
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [IDATA_BIT*MAC_NUM-1:0] idataA,
    input  logic [IDATA_BIT*MAC_NUM-1:0] idataB,
    input  logic                         idata_sign,
    input  logic                         idata_last,
    input  logic                         idata_valid,
    output logic                         idata_ready,
    output logic [ACC_BIT-1:0]           odata,
    output logic                         odata_ovf,
    output logic                         odata_valid,
    input  logic                         odata_ready
);

    localparam int unsigned LEVELS   = $clog2(MAC_NUM);
    localparam int unsigned PROD_BIT = 2 * IDATA_BIT;

    logic en;

    // A result waiting on a stalled consumer freezes every stage.
    assign en          = !(odata_valid && !odata_ready);
    assign idata_ready = en;

    logic [IDATA_BIT*MAC_NUM-1:0] s0_a, s0_b;
    logic                         s0_sign, s0_last, s0_valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s0_a     <= '0;
            s0_b     <= '0;
            s0_sign  <= 1'b0;
            s0_last  <= 1'b0;
            s0_valid <= 1'b0;
        end else if (en) begin
            s0_valid <= idata_valid;
            if (idata_valid) begin
                s0_a    <= idataA;
                s0_b    <= idataB;
                s0_sign <= idata_sign;
                s0_last <= idata_last;
            end
        end
    end

    logic [PROD_BIT-1:0] prod_c [MAC_NUM];

    for (genvar i = 0; i < MAC_NUM; i++) begin : g_mul
        logic [PROD_BIT-1:0] a_x, b_x;
        assign a_x = {{IDATA_BIT{s0_sign & s0_a[i*IDATA_BIT+IDATA_BIT-1]}},
                      s0_a[i*IDATA_BIT+:IDATA_BIT]};
        assign b_x = {{IDATA_BIT{s0_sign & s0_b[i*IDATA_BIT+IDATA_BIT-1]}},
                      s0_b[i*IDATA_BIT+:IDATA_BIT]};
        // Low PROD_BIT bits of the extended product are exact for both sign modes.
        assign prod_c[i] = a_x * b_x;
    end

    logic [PROD_BIT-1:0] s1_prod [MAC_NUM];
    logic                s1_sign, s1_last, s1_valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < MAC_NUM; i++) begin
                s1_prod[i] <= '0;
            end
            s1_sign  <= 1'b0;
            s1_last  <= 1'b0;
            s1_valid <= 1'b0;
        end else if (en) begin
            for (int i = 0; i < MAC_NUM; i++) begin
                s1_prod[i] <= prod_c[i];
            end
            s1_sign  <= s0_sign;
            s1_last  <= s0_last;
            s1_valid <= s0_valid;
        end
    end

    // Adder tree: level 0 holds the extended products; a register follows every second level
    // and the last one. Nodes are carried at full SUM_BIT width, which equals growing by a bit
    // per level.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int unsigned N = MAC_NUM >> l;
        logic [SUM_BIT-1:0] node [N];
        logic               sgn, lst, vld;

        if (l == 0) begin : g_leaf
            for (genvar j = 0; j < N; j++) begin : g_ext
                assign node[j] = {{(SUM_BIT-PROD_BIT){s1_sign & s1_prod[j][PROD_BIT-1]}},
                                  s1_prod[j]};
            end
            assign sgn = s1_sign;
            assign lst = s1_last;
            assign vld = s1_valid;
        end else begin : g_add
            logic [SUM_BIT-1:0] sum_c [N];
            for (genvar j = 0; j < N; j++) begin : g_sum
                assign sum_c[j] = g_lvl[l-1].node[2*j] + g_lvl[l-1].node[2*j+1];
            end
            if ((l % 2 == 0) || (l == LEVELS)) begin : g_reg
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) begin
                        for (int k = 0; k < N; k++) begin
                            node[k] <= '0;
                        end
                        sgn <= 1'b0;
                        lst <= 1'b0;
                        vld <= 1'b0;
                    end else if (en) begin
                        for (int k = 0; k < N; k++) begin
                            node[k] <= sum_c[k];
                        end
                        sgn <= g_lvl[l-1].sgn;
                        lst <= g_lvl[l-1].lst;
                        vld <= g_lvl[l-1].vld;
                    end
                end
            end else begin : g_comb
                assign node = sum_c;
                assign sgn  = g_lvl[l-1].sgn;
                assign lst  = g_lvl[l-1].lst;
                assign vld  = g_lvl[l-1].vld;
            end
        end
    end

    logic [SUM_BIT-1:0] tree_sum;
    logic               tree_sign, tree_last, tree_valid, fin;

    assign tree_sum   = g_lvl[LEVELS].node[0];
    assign tree_sign  = g_lvl[LEVELS].sgn;
    assign tree_last  = g_lvl[LEVELS].lst;
    assign tree_valid = g_lvl[LEVELS].vld;
    assign fin        = tree_valid && tree_last;

    logic [ACC_BIT-1:0] acc_q, acc_next;
    logic [ACC_BIT:0]   acc_x, sum_x, acc_wide;

    assign acc_x    = {tree_sign & acc_q[ACC_BIT-1], acc_q};
    assign sum_x    = {{(ACC_BIT+1-SUM_BIT){tree_sign & tree_sum[SUM_BIT-1]}}, tree_sum};
    assign acc_wide = acc_x + sum_x;

`ifdef CORE_MAC_SAT_EN
    localparam logic [ACC_BIT-1:0] ACC_SMAX = {1'b0, {(ACC_BIT-1){1'b1}}};
    localparam logic [ACC_BIT-1:0] ACC_SMIN = {1'b1, {(ACC_BIT-1){1'b0}}};

    logic ovf, sticky_q;

    always_comb begin
        ovf      = 1'b0;
        acc_next = acc_wide[ACC_BIT-1:0];
        if (tree_sign) begin
            ovf = acc_wide[ACC_BIT] != acc_wide[ACC_BIT-1];
            if (ovf) begin
                acc_next = acc_wide[ACC_BIT] ? ACC_SMIN : ACC_SMAX;
            end
        end else begin
            ovf = acc_wide[ACC_BIT];
            if (ovf) begin
                acc_next = '1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sticky_q  <= 1'b0;
            odata_ovf <= 1'b0;
        end else if (en && tree_valid) begin
            sticky_q <= tree_last ? 1'b0 : (sticky_q | ovf);
            if (tree_last) begin
                odata_ovf <= sticky_q | ovf;
            end
        end
    end
`else
    logic unused_carry;

    assign acc_next     = acc_wide[ACC_BIT-1:0];
    assign unused_carry = acc_wide[ACC_BIT];
    assign odata_ovf    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q       <= '0;
            odata       <= '0;
            odata_valid <= 1'b0;
        end else if (en) begin
            odata_valid <= fin;
            if (fin) begin
                odata <= acc_next;
            end
            if (tree_valid) begin
                acc_q <= tree_last ? '0 : acc_next;
            end
        end
    end

endmodule

// File: tb/tb_core_mac_acc.sv
// Bench for core_mac_acc (MAC_NUM=4, IDATA_BIT=8, ACC_BIT=20): a dot-product model feeds a
// result queue checked every cycle, plus literal expectations for directed vectors.
module tb_core_mac_acc;

    localparam int MAC_NUM   = 4;
    localparam int IDATA_BIT = 8;
    localparam int ACC_BIT   = 20;
    localparam int LAT       = 4;
    localparam int W         = MAC_NUM * IDATA_BIT;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic [W-1:0]       idataA = '0;
    logic [W-1:0]       idataB = '0;
    logic               idata_sign = 1'b0;
    logic               idata_last = 1'b0;
    logic               idata_valid = 1'b0;
    logic               idata_ready;
    logic [ACC_BIT-1:0] odata;
    logic               odata_ovf;
    logic               odata_valid;
    logic               odata_ready = 1'b1;

    core_mac_acc #(
        .MAC_NUM  (MAC_NUM),
        .IDATA_BIT(IDATA_BIT),
        .ACC_BIT  (ACC_BIT)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .idataA     (idataA),
        .idataB     (idataB),
        .idata_sign (idata_sign),
        .idata_last (idata_last),
        .idata_valid(idata_valid),
        .idata_ready(idata_ready),
        .odata      (odata),
        .odata_ovf  (odata_ovf),
        .odata_valid(odata_valid),
        .odata_ready(odata_ready)
    );

    initial forever #5 clk = ~clk;

    int                 n_cmp = 0;
    int                 n_fail = 0;
    int                 n_out = 0;
    logic [ACC_BIT-1:0] last_out = '0;
    logic               last_ovf = 1'b0;
    logic [ACC_BIT-1:0] exp_data_q[$];
    bit                 exp_ovf_q[$];
    longint             m_acc = 0;
    bit                 m_sticky = 1'b0;
    int                 rdy_mode = 0;  // 0: ready high, 1: random, 2: held low

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint lane_val(input logic [IDATA_BIT-1:0] v, input bit s);
        return s ? longint'($signed(v)) : longint'(v);
    endfunction

    // Golden model: whole-beat dot product added to a range-limited accumulator.
    task automatic model_beat(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                              input bit last);
        longint d;
        longint v;
        longint lo;
        longint hi;
        d = 0;
        for (int i = 0; i < MAC_NUM; i++) begin
            d += lane_val(a[i*IDATA_BIT+:IDATA_BIT], s) * lane_val(b[i*IDATA_BIT+:IDATA_BIT], s);
        end
        v = m_acc + d;
`ifdef CORE_MAC_SAT_EN
        lo = s ? -(longint'(1) <<< (ACC_BIT - 1)) : 0;
        hi = s ? (longint'(1) <<< (ACC_BIT - 1)) - 1 : (longint'(1) <<< ACC_BIT) - 1;
        if (v > hi) begin
            v = hi;
            m_sticky = 1'b1;
        end else if (v < lo) begin
            v = lo;
            m_sticky = 1'b1;
        end
`else
        lo = 0;
        hi = (longint'(1) <<< ACC_BIT) - 1;
        v = v & hi;
`endif
        if (last) begin
            exp_data_q.push_back(v[ACC_BIT-1:0]);
            exp_ovf_q.push_back(m_sticky);
            m_acc = 0;
            m_sticky = 1'b0;
        end else begin
            m_acc = v;
        end
    endtask

    task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                             input bit last);
        bit ok;
        int t;
        ok = 1'b0;
        t = 0;
        idataA = a;
        idataB = b;
        idata_sign = s;
        idata_last = last;
        idata_valid = 1'b1;
        while (!ok && t < 200) begin
            @(negedge clk);
            ok = idata_ready;
            @(posedge clk);
            #1;
            t++;
        end
        check("beat_accept", ok, 1);
        if (ok) model_beat(a, b, s, last);
        idata_valid = 1'b0;
    endtask

    task automatic wait_out(input int target, input int budget);
        int t;
        t = 0;
        while (n_out < target && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("result_arrival", n_out >= target, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int t;
        t = 0;
        while (exp_data_q.size() != 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending", exp_data_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            1:       odata_ready = ($urandom_range(0, 3) != 0);
            2:       odata_ready = 1'b0;
            default: odata_ready = 1'b1;
        endcase
    end

    // Compare process: every cycle, on the falling edge.
    initial begin
        bit                 hold_pend;
        logic [ACC_BIT-1:0] hold_d;
        logic               hold_o;
        logic [ACC_BIT-1:0] ed;
        bit                 eo;
        hold_pend = 1'b0;
        hold_d = '0;
        hold_o = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                hold_pend = 1'b0;
                continue;
            end
            check("idata_ready_rule", idata_ready, !(odata_valid && !odata_ready));
            if (hold_pend) begin
                check("hold_valid", odata_valid, 1);
                check("hold_data", odata, hold_d);
                check("hold_ovf", odata_ovf, hold_o);
            end
            if (odata_valid && odata_ready) begin
                check("result_expected", exp_data_q.size() > 0, 1);
                if (exp_data_q.size() > 0) begin
                    ed = exp_data_q.pop_front();
                    eo = exp_ovf_q.pop_front();
                    check("odata", odata, ed);
                    check("odata_ovf", odata_ovf, eo);
                end
                n_out++;
                last_out = odata;
                last_ovf = odata_ovf;
            end
            hold_pend = odata_valid && !odata_ready;
            hold_d = odata;
            hold_o = odata_ovf;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got time %0t, expected earlier finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int len;
        repeat (3) @(posedge clk);
        #1;
        check("rst_odata_valid", odata_valid, 0);
        check("rst_idata_ready", idata_ready, 1);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("rst_odata", odata, 0);
        check("rst_odata_ovf", odata_ovf, 0);
        check("rst_valid_after", odata_valid, 0);

        // Unsigned single beat, with latency counted from the accepting edge.
        base = n_out;
        send_beat(32'h04030201, 32'h04030201, 1'b0, 1'b1);
        for (int k = 1; k < LAT; k++) begin
            @(posedge clk);
            #1;
            check("latency_valid", odata_valid, (k == LAT - 1));
        end
        wait_out(base + 1, 20);
        check("t1_data", last_out, 30);
        check("t1_ovf", last_ovf, 0);

        // Signed, two beats of -128*127 per lane.
        base = n_out;
        send_beat(32'h80808080, 32'h7f7f7f7f, 1'b1, 1'b0);
        send_beat(32'h80808080, 32'h7f7f7f7f, 1'b1, 1'b1);
        wait_out(base + 1, 20);
        check("t2_data", last_out, 20'he0400);
        check("t2_ovf", last_ovf, 0);

        // Unsigned overflow of a 20-bit accumulator.
        base = n_out;
        for (int i = 0; i < 5; i++) send_beat('1, '1, 1'b0, (i == 4));
        wait_out(base + 1, 20);
`ifdef CORE_MAC_SAT_EN
        check("t3_data", last_out, 1048575);
        check("t3_ovf", last_ovf, 1);
`else
        check("t3_data", last_out, 251924);
        check("t3_ovf", last_ovf, 0);
`endif

        // Signed positive and negative overflow.
        base = n_out;
        for (int i = 0; i < 10; i++) send_beat(32'h80808080, 32'h80808080, 1'b1, (i == 9));
        wait_out(base + 1, 20);
`ifdef CORE_MAC_SAT_EN
        check("t4p_data", last_out, 20'h7ffff);
        check("t4p_ovf", last_ovf, 1);
`else
        check("t4p_data", last_out, 20'ha0000);
        check("t4p_ovf", last_ovf, 0);
`endif
        base = n_out;
        for (int i = 0; i < 10; i++) send_beat(32'h80808080, 32'h7f7f7f7f, 1'b1, (i == 9));
        wait_out(base + 1, 20);
`ifdef CORE_MAC_SAT_EN
        check("t4n_data", last_out, 20'h80000);
        check("t4n_ovf", last_ovf, 1);
`else
        check("t4n_data", last_out, 398336);
        check("t4n_ovf", last_ovf, 0);
`endif

        // Three back-to-back single-beat vectors with a 5-cycle consumer stall.
        base = n_out;
        fork
            begin
                send_beat(32'h01010101, 32'h01010101, 1'b0, 1'b1);
                send_beat(32'h02020202, 32'h01010101, 1'b0, 1'b1);
                send_beat(32'h03030303, 32'h01010101, 1'b0, 1'b1);
            end
            begin
                int t;
                t = 0;
                while (!odata_valid && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                rdy_mode = 2;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_idata_ready", idata_ready, 0);
                end
                rdy_mode = 0;
            end
        join
        drain(100);
        check("stall_result_count", n_out - base, 3);
        check("stall_last_data", last_out, 12);

        // Random vectors, gaps and backpressure in both sign modes.
        rdy_mode = 1;
        for (int s = 0; s < 2; s++) begin
            for (int v = 0; v < 10; v++) begin
                len = $urandom_range(1, 16);
                for (int b = 0; b < len; b++) begin
                    send_beat($urandom, $urandom, s[0], (b == len - 1));
                    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
            end
        end
        rdy_mode = 0;
        drain(2000);

        // Reset mid-vector, then a fresh single beat.
        send_beat(32'h11111111, 32'h22222222, 1'b0, 1'b0);
        send_beat(32'h33333333, 32'h44444444, 1'b0, 1'b0);
        rstn = 1'b0;
        m_acc = 0;
        m_sticky = 1'b0;
        exp_data_q.delete();
        exp_ovf_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_valid", odata_valid, 0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        base = n_out;
        send_beat(32'h01010101, 32'h02020202, 1'b0, 1'b1);
        wait_out(base + 1, 20);
        check("post_rst_data", last_out, 8);
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_count", n_out - base, 1);
        drain(50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
